// File: rtl/writeback_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : writeback_arbiter
// Purpose  : Shares the register-file write port between the ALU and load
//            writeback paths. A starvation boost guarantees ALU progress.
// Revision : 1.0
//------------------------------------------------------------------------------
module writeback_arbiter #(
   parameter int XLEN         = 32,
   parameter int REG_AW       = 5,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_alu_valid,
   input  logic [REG_AW-1:0] i_alu_rd,
   input  logic [XLEN-1:0]   i_alu_data,
   output logic              o_alu_ready,
   input  logic              i_ld_valid,
   input  logic [REG_AW-1:0] i_ld_rd,
   input  logic [XLEN-1:0]   i_ld_data,
   output logic              o_ld_ready,
   output logic              o_rf_we,
   output logic [REG_AW-1:0] o_rf_waddr,
   output logic [XLEN-1:0]   o_rf_wdata,
   output logic              o_retire,
   output logic              o_retire_src
);

   localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

   typedef enum logic [0:0] {
      ST_NORMAL = 1'b0,
      ST_BOOST  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [3:0]        starve_q, starve_d;
   logic              gnt_alu, gnt_ld, gnt_any;
   logic [REG_AW-1:0] win_rd;
   logic [XLEN-1:0]   win_data;

   always_comb begin
      gnt_alu  = 1'b0;
      gnt_ld   = 1'b0;
      state_d  = state_q;
      starve_d = starve_q;

      if (state_q == ST_BOOST) begin
         gnt_alu = i_alu_valid;
         gnt_ld  = i_ld_valid && !i_alu_valid;
      end else begin
         gnt_ld  = i_ld_valid;
         gnt_alu = i_alu_valid && !i_ld_valid;
      end

      // Counts consecutive denials of a waiting ALU result, saturating.
      if (!i_alu_valid || gnt_alu) begin
         starve_d = 4'd0;
      end else if (starve_q < C_LIMIT) begin
         starve_d = starve_q + 4'd1;
      end

      case (state_q)
         ST_NORMAL: if (starve_d == C_LIMIT)        state_d = ST_BOOST;
         ST_BOOST:  if (!i_alu_valid || gnt_alu)    state_d = ST_NORMAL;
         default:                                   state_d = ST_NORMAL;
      endcase
   end

   assign gnt_any     = gnt_alu || gnt_ld;
   assign win_rd      = gnt_alu ? i_alu_rd   : i_ld_rd;
   assign win_data    = gnt_alu ? i_alu_data : i_ld_data;
   assign o_alu_ready = gnt_alu && !i_reset;
   assign o_ld_ready  = gnt_ld  && !i_reset;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q      <= ST_NORMAL;
         starve_q     <= 4'd0;
         o_rf_we      <= 1'b0;
         o_rf_waddr   <= '0;
         o_rf_wdata   <= '0;
         o_retire     <= 1'b0;
         o_retire_src <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         o_retire <= gnt_any;
         o_rf_we  <= gnt_any && (win_rd != '0);
         if (gnt_any) begin
            o_retire_src <= gnt_ld;
         end
         // x0 writes retire but leave the visible write address/data untouched.
         if (gnt_any && (win_rd != '0)) begin
            o_rf_waddr <= win_rd;
            o_rf_wdata <= win_data;
         end
      end
   end

endmodule
`default_nettype wire
